// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP serial-clock frame sequencer.
package ssp_pkg;

  typedef enum logic [1:0] {IDLE, LEAD, ACTIVE, TRAIL} ssp_state_e;

  localparam int unsigned DSS_MIN        = 3;
  localparam int unsigned DSS_RESERVED_N = 4;
  localparam logic [1:0]  FRF_SPI        = 2'b00;

endpackage

// File: rtl/ssp_half_period_cntr.sv
// Half-period counter: counts SSPCLKDIV ticks and flags the tick that ends each SCLK half period.
module ssp_half_period_cntr #(
  parameter int unsigned SCR_W = 8
) (
  input  logic             SSPCLK,
  input  logic             SSPRST,
  input  logic             clear,
  input  logic             SSPCLKDIV,
  input  logic [SCR_W-1:0] scr,
  output logic             half_tick
);

  logic [SCR_W-1:0] scr_cnt;

  assign half_tick = SSPCLKDIV & (scr_cnt == scr);

  always_ff @(posedge SSPCLK) begin
    if (SSPRST || clear) begin
      scr_cnt <= '0;
    end else if (half_tick) begin
      scr_cnt <= '0;
    end else if (SSPCLKDIV) begin
      scr_cnt <= scr_cnt + SCR_W'(1);
    end
  end

endmodule

// File: rtl/ssp_sclk_sequencer.sv
// SPI-master frame sequencer: SCLK/FSS generation plus shift/sample strobes per frame.
// Build option SSP_SCLK_CONT_FSS_EN: back-to-back SPH=1 frames keep FSS low.
module ssp_sclk_sequencer
  import ssp_pkg::*;
#(
  parameter int unsigned SCR_W = 8,
  parameter int unsigned DSS_W = 4
) (
  input  logic             SSPCLK,
  input  logic             SSPRST,
  input  logic             SSE,
  input  logic             SSPCLKDIV,
  input  logic             SPO,
  input  logic             SPH,
  input  logic [DSS_W-1:0] DSS,
  input  logic [SCR_W-1:0] SCR,
  input  logic             TxValid,
  output logic             TxReady,
  output logic             ShiftEn,
  output logic             SampleEn,
  output logic [DSS_W-1:0] BitCnt,
  output logic             RxValid,
  output logic             Busy,
  output logic             SSPCLKOUT,
  output logic             SSPFSSOUT
);

  localparam int unsigned N_W = DSS_W + 1;
  localparam int unsigned E_W = DSS_W + 2;

  ssp_state_e       state;
  logic             spo_l;
  logic             sph_l;
  logic [SCR_W-1:0] scr_l;
  logic [N_W-1:0]   n_l;
  logic [N_W-1:0]   n_sel;
  logic [E_W-1:0]   edge_cnt;
  logic [E_W-1:0]   edge_nxt;
  logic [E_W-1:0]   edge_last;
  logic             half_tick;
  logic             cnt_clear;
  logic             cont_start;
  logic             start;

  // Reserved data sizes fall back to the minimum 4-bit frame.
  assign n_sel     = (DSS < DSS_W'(DSS_MIN)) ? N_W'(DSS_RESERVED_N) : N_W'(DSS) + N_W'(1);
  assign edge_nxt  = edge_cnt + E_W'(1);
  assign edge_last = {n_l, 1'b0};

`ifdef SSP_SCLK_CONT_FSS_EN
  assign cont_start = (state == TRAIL) & half_tick & sph_l & TxValid & SSE;
`else
  assign cont_start = 1'b0;
`endif

  assign TxReady   = ((state == IDLE) & SSE) | cont_start;
  assign start     = TxValid & TxReady;
  assign cnt_clear = (state == IDLE) | start;

  ssp_half_period_cntr #(.SCR_W(SCR_W)) u_half_period_cntr (
    .SSPCLK    (SSPCLK),
    .SSPRST    (SSPRST),
    .clear     (cnt_clear),
    .SSPCLKDIV (SSPCLKDIV),
    .scr       (scr_l),
    .half_tick (half_tick)
  );

  always_ff @(posedge SSPCLK) begin
    if (SSPRST) begin
      state     <= IDLE;
      spo_l     <= 1'b0;
      sph_l     <= 1'b0;
      scr_l     <= '0;
      n_l       <= N_W'(DSS_RESERVED_N);
      edge_cnt  <= '0;
      BitCnt    <= '0;
      ShiftEn   <= 1'b0;
      SampleEn  <= 1'b0;
      RxValid   <= 1'b0;
      Busy      <= 1'b0;
      SSPCLKOUT <= 1'b0;
      SSPFSSOUT <= 1'b1;
    end else begin
      ShiftEn  <= 1'b0;
      SampleEn <= 1'b0;
      RxValid  <= 1'b0;
      if (!SSE) begin
        state     <= IDLE;
        Busy      <= 1'b0;
        SSPFSSOUT <= 1'b1;
        SSPCLKOUT <= SPO;
        BitCnt    <= '0;
        edge_cnt  <= '0;
      end else begin
        if (start) begin
          spo_l <= SPO;
          sph_l <= SPH;
          scr_l <= SCR;
          n_l   <= n_sel;
        end
        unique case (state)
          IDLE: begin
            SSPCLKOUT <= SPO;
            if (start) begin
              state     <= LEAD;
              Busy      <= 1'b1;
              SSPFSSOUT <= 1'b0;
              edge_cnt  <= '0;
              BitCnt    <= '0;
              ShiftEn   <= ~SPH;
            end
          end
          LEAD: begin
            SSPCLKOUT <= spo_l;
            if (half_tick) state <= ACTIVE;
          end
          // Odd/even edge role swaps with phase; the final edge never shifts.
          ACTIVE: begin
            if (half_tick) begin
              SSPCLKOUT <= ~SSPCLKOUT;
              edge_cnt  <= edge_nxt;
              if (edge_nxt[0] ^ sph_l) begin
                SampleEn <= 1'b1;
                BitCnt   <= BitCnt + DSS_W'(1);
              end else if (edge_nxt != edge_last) begin
                ShiftEn <= 1'b1;
              end
              if (edge_nxt == edge_last) state <= TRAIL;
            end
          end
          TRAIL: begin
            SSPCLKOUT <= spo_l;
            if (half_tick) begin
              RxValid <= 1'b1;
              if (cont_start) begin
                state     <= ACTIVE;
                SSPCLKOUT <= SPO;
                edge_cnt  <= '0;
                BitCnt    <= '0;
                ShiftEn   <= ~SPH;
              end else begin
                state     <= IDLE;
                Busy      <= 1'b0;
                SSPFSSOUT <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssp_sclk_sequencer.sv
// Directed bench for ssp_sclk_sequencer with hand-computed frame expectations.
module tb_ssp_sclk_sequencer;

  logic       SSPCLK;
  logic       SSPRST;
  logic       SSE;
  logic       SSPCLKDIV;
  logic       SPO;
  logic       SPH;
  logic [3:0] DSS;
  logic [7:0] SCR;
  logic       TxValid;
  logic       TxReady;
  logic       ShiftEn;
  logic       SampleEn;
  logic [3:0] BitCnt;
  logic       RxValid;
  logic       Busy;
  logic       SSPCLKOUT;
  logic       SSPFSSOUT;

  int n_vec = 0;
  int n_err = 0;
  int div_per = 1;
  int div_cnt = 0;

  int m_fss, m_edges, m_first, m_last, m_shift, m_shift0, m_shift_fall;
  int m_samp, m_samp_rise, m_rxv, m_bit;

  ssp_sclk_sequencer dut (
    .SSPCLK    (SSPCLK),
    .SSPRST    (SSPRST),
    .SSE       (SSE),
    .SSPCLKDIV (SSPCLKDIV),
    .SPO       (SPO),
    .SPH       (SPH),
    .DSS       (DSS),
    .SCR       (SCR),
    .TxValid   (TxValid),
    .TxReady   (TxReady),
    .ShiftEn   (ShiftEn),
    .SampleEn  (SampleEn),
    .BitCnt    (BitCnt),
    .RxValid   (RxValid),
    .Busy      (Busy),
    .SSPCLKOUT (SSPCLKOUT),
    .SSPFSSOUT (SSPFSSOUT)
  );

  initial begin
    SSPCLK = 1'b0;
    forever #5 SSPCLK = ~SSPCLK;
  end

  // Prescaler tick: one cycle in every div_per
  initial begin
    SSPCLKDIV = 1'b0;
    forever begin
      @(posedge SSPCLK);
      #1;
      div_cnt   = (div_cnt + 1 >= div_per) ? 0 : div_cnt + 1;
      SSPCLKDIV = (div_cnt == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge SSPCLK);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input string tag);
    check({tag, "_txready"}, 32'(TxReady), 32'd1);
    TxValid = 1'b1;
    tick;
    TxValid = 1'b0;
  endtask

  // Observes one frame from the first FSS-low cycle up to RxValid, then a short tail.
  task automatic measure(input int budget);
    logic prev;
    bit   done;
    m_fss = 0; m_edges = 0; m_first = -1; m_last = -1; m_shift = 0; m_shift0 = 0;
    m_shift_fall = 0; m_samp = 0; m_samp_rise = 0; m_rxv = 0; m_bit = -1;
    prev = SSPCLKOUT;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (RxValid) begin
        m_rxv++;
        m_bit = int'(BitCnt);
        done  = 1'b1;
        break;
      end
      if (!SSPFSSOUT) m_fss++;
      if (SSPCLKOUT != prev) begin
        m_edges++;
        if (m_first < 0) m_first = c;
        m_last = c;
      end
      if (ShiftEn) begin
        m_shift++;
        if (c == 0) m_shift0 = 1;
        if (prev && !SSPCLKOUT) m_shift_fall++;
      end
      if (SampleEn) begin
        m_samp++;
        if (!prev && SSPCLKOUT) m_samp_rise++;
      end
      prev = SSPCLKOUT;
      tick;
    end
    if (done) begin
      for (int k = 0; k < 4; k++) begin
        tick;
        if (RxValid) m_rxv++;
      end
    end
  endtask

  initial begin
    int e;
    int r;
    int hi;
    bit started;
    logic prev;

    SSPRST = 1'b1; SSE = 1'b0; SPO = 1'b0; SPH = 1'b0;
    DSS = 4'd7; SCR = 8'd0; TxValid = 1'b0;
    tick; tick; tick;
    SSPRST = 1'b0;
    tick;

    // Reset state
    check("rst_sclk", 32'(SSPCLKOUT), 32'd0);
    check("rst_fss", 32'(SSPFSSOUT), 32'd1);
    check("rst_strobes", 32'({ShiftEn, SampleEn, RxValid}), 32'd0);
    check("rst_bitcnt", 32'(BitCnt), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("txready_sse0", 32'(TxReady), 32'd0);
    SSE = 1'b1;
    #1;
    check("txready_sse1", 32'(TxReady), 32'd1);
    tick;

    // 1: 8-bit frame, SCR=0, tick every cycle, SPO=0 SPH=0
    start_frame("t1");
    measure(200);
    check("t1_fss_low", 32'(m_fss), 32'd18);
    check("t1_edges", 32'(m_edges), 32'd16);
    check("t1_edge_span", 32'(m_last - m_first), 32'd15);
    check("t1_shift_start", 32'(m_shift0), 32'd1);
    check("t1_shift", 32'(m_shift), 32'd8);
    check("t1_shift_fall", 32'(m_shift_fall), 32'd7);
    check("t1_sample", 32'(m_samp), 32'd8);
    check("t1_sample_rise", 32'(m_samp_rise), 32'd8);
    check("t1_rxvalid", 32'(m_rxv), 32'd1);
    check("t1_bitcnt", 32'(m_bit), 32'd8);
    check("t1_busy_end", 32'(Busy), 32'd0);
    check("t1_fss_end", 32'(SSPFSSOUT), 32'd1);

    // 2: SCR=2, tick every 2nd cycle, 4-bit frame -> half period 6 cycles
    div_per = 2; SCR = 8'd2; DSS = 4'd3;
    tick; tick;
    start_frame("t2");
    measure(300);
    check("t2_edges", 32'(m_edges), 32'd8);
    check("t2_edge_span", 32'(m_last - m_first), 32'd42);
    check("t2_sample", 32'(m_samp), 32'd4);
    check("t2_shift", 32'(m_shift), 32'd4);
    check("t2_rxvalid", 32'(m_rxv), 32'd1);
    check("t2_bitcnt", 32'(m_bit), 32'd4);

    // 3: SPO=1, SPH=1, reserved DSS=2 -> 4-bit frame
    div_per = 1; SCR = 8'd0; DSS = 4'd2; SPO = 1'b1; SPH = 1'b1;
    tick; tick;
    check("t3_idle_sclk", 32'(SSPCLKOUT), 32'd1);
    start_frame("t3");
    measure(200);
    check("t3_fss_low", 32'(m_fss), 32'd10);
    check("t3_edges", 32'(m_edges), 32'd8);
    check("t3_shift_start", 32'(m_shift0), 32'd0);
    check("t3_shift_fall", 32'(m_shift_fall), 32'd4);
    check("t3_shift", 32'(m_shift), 32'd4);
    check("t3_sample_rise", 32'(m_samp_rise), 32'd4);
    check("t3_sample", 32'(m_samp), 32'd4);
    check("t3_bitcnt", 32'(m_bit), 32'd4);
    check("t3_idle_sclk_end", 32'(SSPCLKOUT), 32'd1);
    SPO = 1'b0; SPH = 1'b0;
    tick; tick;
    check("t3_sclk_follows_spo", 32'(SSPCLKOUT), 32'd0);

    // 4: SSE dropped after edge 5 aborts the frame
    DSS = 4'd7;
    start_frame("t4");
    prev = SSPCLKOUT;
    e = 0;
    for (int c = 0; c < 50; c++) begin
      if (SSPCLKOUT != prev) e++;
      prev = SSPCLKOUT;
      if (e == 5) break;
      tick;
    end
    check("t4_reach_edge5", 32'(e), 32'd5);
    check("t4_sclk_at_edge5", 32'(SSPCLKOUT), 32'd1);
    SSE = 1'b0;
    tick;
    check("t4_abort_fss", 32'(SSPFSSOUT), 32'd1);
    check("t4_abort_sclk", 32'(SSPCLKOUT), 32'd0);
    check("t4_abort_busy", 32'(Busy), 32'd0);
    check("t4_abort_bitcnt", 32'(BitCnt), 32'd0);
    check("t4_abort_txready", 32'(TxReady), 32'd0);
    r = 0;
    for (int k = 0; k < 6; k++) begin
      if (RxValid) r++;
      tick;
    end
    check("t4_no_rxvalid", 32'(r), 32'd0);
    SSE = 1'b1;
    #1;
    check("t4_txready_back", 32'(TxReady), 32'd1);
    tick;

    // 5: SCR change mid-frame only affects the following frame
    DSS = 4'd3; SCR = 8'd0;
    start_frame("t5a");
    SCR = 8'd5;
    measure(200);
    check("t5a_edge_span", 32'(m_last - m_first), 32'd7);
    check("t5a_fss_low", 32'(m_fss), 32'd10);
    check("t5a_rxvalid", 32'(m_rxv), 32'd1);
    start_frame("t5b");
    measure(300);
    check("t5b_edge_span", 32'(m_last - m_first), 32'd42);
    check("t5b_fss_low", 32'(m_fss), 32'd60);
    check("t5b_rxvalid", 32'(m_rxv), 32'd1);
    SCR = 8'd0;
    tick;

    // Synchronous reset beats an active frame
    DSS = 4'd7;
    start_frame("rst_mid");
    tick; tick; tick; tick;
    check("rst_mid_busy_pre", 32'(Busy), 32'd1);
    SSPRST = 1'b1;
    tick;
    SSPRST = 1'b0;
    check("rst_mid_fss", 32'(SSPFSSOUT), 32'd1);
    check("rst_mid_busy", 32'(Busy), 32'd0);
    check("rst_mid_sclk", 32'(SSPCLKOUT), 32'd0);
    check("rst_mid_bitcnt", 32'(BitCnt), 32'd0);
    tick;

    // 6: TxValid held with SPH=1 -> FSS gap between frames depends on build option
    DSS = 4'd3; SPH = 1'b1;
    tick;
    TxValid = 1'b1;
    started = 1'b0; hi = 0; r = 0;
    for (int c = 0; c < 300; c++) begin
      if (RxValid) r++;
      if (r == 2) break;
      if (!SSPFSSOUT) started = 1'b1;
      else if (started) hi++;
      tick;
    end
    TxValid = 1'b0;
    check("t6_two_frames", 32'(r), 32'd2);
`ifdef SSP_SCLK_CONT_FSS_EN
    check("t6_fss_gap", 32'(hi), 32'd0);
`else
    check("t6_fss_gap", 32'(hi), 32'd1);
`endif
    SSE = 1'b0;
    tick;
    SSE = 1'b1; SPH = 1'b0;
    tick;
    check("t6_idle_after", 32'(Busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
